// File: rtl/fetch_controller_if.sv
// Fetch-side bus bundle: instruction-memory request/response and decode handoff.
// master = fetch_controller, slave = memory/decode side.
interface fetch_controller_if;
    localparam int unsigned XLEN = 32;

    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            dec_valid;
    logic [XLEN-1:0] dec_pc;
    logic [XLEN-1:0] dec_instr;
    logic            dec_ready;

    modport master (
        output imem_req_valid, imem_req_addr, dec_valid, dec_pc, dec_instr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, dec_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, dec_valid, dec_pc, dec_instr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, dec_ready
    );
endinterface

// File: rtl/fetch_controller.sv
// Fetch sequencer: owns the PC, issues one-outstanding imem requests, hands words to decode,
// and squashes wrong-path fetches on redirect. Optional trap redirect via `FETCH_TRAP_EN.
module fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect_en,
    input  logic [31:0]         redirect_pc,
`ifdef FETCH_TRAP_EN
    input  logic                trap_en,
    input  logic [31:0]         trap_vec,
    output logic                fetch_misaligned,
`endif
    fetch_controller_if.master  bus,
    output logic [31:0]         pc
);
    localparam int unsigned XLEN    = 32;
    localparam int unsigned PC_STEP = 4;

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t          r_state, w_state_nxt;
    logic [XLEN-1:0] r_pc, w_pc_nxt;
    logic            r_drop, w_drop_nxt;
    logic [XLEN-1:0] r_dec_pc, w_dec_pc_nxt;
    logic [XLEN-1:0] r_dec_instr, w_dec_instr_nxt;

    logic            w_redir;
    logic [XLEN-1:0] w_target;
    logic            w_req_valid;
    logic            w_req_fire;

`ifdef FETCH_TRAP_EN
    logic r_misaligned, w_misaligned_nxt;

    // Trap wins over redirect; a misaligned redirect is diverted to the trap vector.
    assign w_redir          = trap_en | redirect_en;
    assign w_misaligned_nxt = ~trap_en & redirect_en & (|redirect_pc[1:0]);
    assign w_target         = (trap_en | w_misaligned_nxt) ? {trap_vec[XLEN-1:2], 2'b00}
                                                           : redirect_pc;
    assign fetch_misaligned = r_misaligned;
`else
    logic w_unused_pc_lsbs;

    assign w_redir          = redirect_en;
    assign w_target         = {redirect_pc[XLEN-1:2], 2'b00};
    assign w_unused_pc_lsbs = ^redirect_pc[1:0];
`endif

    assign w_req_valid        = (r_state == S_REQ) & ~rst;
    assign w_req_fire         = w_req_valid & bus.imem_req_ready;

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_pc;
    // Combinational mask so a redirect squashes the held word in the same cycle.
    assign bus.dec_valid      = (r_state == S_HOLD) & ~w_redir & ~rst;
    assign bus.dec_pc         = r_dec_pc;
    assign bus.dec_instr      = r_dec_instr;
    assign pc                 = r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_REQ;
            r_pc        <= RESET_PC;
            r_drop      <= 1'b0;
            r_dec_pc    <= '0;
            r_dec_instr <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_drop      <= w_drop_nxt;
            r_dec_pc    <= w_dec_pc_nxt;
            r_dec_instr <= w_dec_instr_nxt;
        end
    end

`ifdef FETCH_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) r_misaligned <= 1'b0;
        else     r_misaligned <= w_misaligned_nxt;
    end
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_drop_nxt      = r_drop;
        w_dec_pc_nxt    = r_dec_pc;
        w_dec_instr_nxt = r_dec_instr;

        unique case (r_state)
            S_REQ: begin
                if (w_redir) w_pc_nxt = w_target;
                // A redirect racing an accepted request leaves a stale response in flight.
                if (w_req_fire) begin
                    w_state_nxt = S_WAIT;
                    w_drop_nxt  = w_redir;
                end
            end
            S_WAIT: begin
                if (w_redir) begin
                    w_pc_nxt   = w_target;
                    w_drop_nxt = 1'b1;
                end
                if (bus.imem_rsp_valid) begin
                    if (r_drop || w_redir) begin
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_dec_instr_nxt = bus.imem_rsp_data;
                        w_dec_pc_nxt    = r_pc;
                        w_pc_nxt        = r_pc + XLEN'(PC_STEP);
                        w_state_nxt     = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (w_redir) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = S_REQ;
                end else if (bus.dec_ready) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_REQ;
        endcase
    end
endmodule
